uart_int_ctrl: RTL
==================

# uart_int_ctrl

Parametrised interrupt controller for the APB UART. Collects NUM_SRC interrupt sources (default six: parity error, framing error, break, TX overflow, RX overflow, RX data) into sticky pending bits with per-source enable, edge/level mode and write-1-to-clear. Applies event-count / timeout coalescing before driving a single registered `irq_o` to the system. Sits between the UART core's raw status strobes and the APB register block, which supplies configuration and clear writes.

## Interface
- NUM_SRC, 6: number of interrupt sources
- CNT_W, 8: width of coalescing event counter and threshold
- TMO_W, 16: width of coalescing timeout timer and limit

- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- src_i  in  NUM_SRC  raw source signals from UART core
- mode_i  in  NUM_SRC  per source: 1 = rising-edge capture, 0 = level capture
- en_i  in  NUM_SRC  per-source enable (mask for irq, not for capture)
- clr_we_i  in  1  clear write strobe from register block
- clr_i  in  NUM_SRC  write-1-to-clear vector, valid when clr_we_i=1
- coal_thr_i  in  CNT_W  event-cycle threshold; 0 or 1 = no coalescing
- coal_tmo_i  in  TMO_W  coalescing timeout in pclk cycles; 0 = no timeout
- raw_sts_o  out  NUM_SRC  pending bits, independent of en_i
- msk_sts_o  out  NUM_SRC  raw_sts_o & en_i (combinational)
- evt_cnt_o  out  CNT_W  current coalescing count
- irq_o  out  1  interrupt request, registered

## Operation
- Per source: `src_q` holds previous src_i. Set condition = mode ? (src & ~src_q) : src.
- Pending bit: set on set condition; cleared when clr_we_i & clr_i; set wins over clear in the same cycle. Level source still high after clear re-pends next edge.
- Capture is independent of en_i; enabling a pending source exposes it immediately in msk_sts_o.
- New-event cycle = any bit with set condition & en_i & pending not already set. Counts as one event per cycle regardless of how many bits.
- FSM states IDLE, ACCUM, ASSERT (from package):
  - IDLE: cnt=0, tmr=0. New-event cycle → ASSERT if coal_thr_i ≤ 1, else ACCUM with cnt=1.
  - ACCUM: tmr increments each cycle; cnt increments per new-event cycle, saturating at 2^CNT_W−1. → ASSERT when updated cnt ≥ coal_thr_i, or coal_tmo_i≠0 and updated tmr = coal_tmo_i. → IDLE if next msk_sts = 0 (software clear or disable).
  - ASSERT: irq_o=1. → IDLE when next msk_sts = 0; cnt and tmr reset on entry to IDLE.
- irq_o = registered (state == ASSERT).
- coal_thr_i and coal_tmo_i are compared live; lowering the threshold below cnt in ACCUM asserts on the next edge.
- evt_cnt_o = cnt.

## Timing
- Reset: all pending bits, src_q, cnt, tmr 0; state IDLE; irq_o=0, raw_sts_o=0, msk_sts_o=0, evt_cnt_o=0.
- Reset mid-operation drops irq_o and all pending state asynchronously.
- Latency with no coalescing: src_i set condition sampled at edge k → raw_sts_o and irq_o high after edge k (1 cycle).
- Clear: clr_we_i at edge k → raw_sts_o bit low after edge k; if msk_sts becomes 0, irq_o low after edge k.
- Timeout: irq_o rises exactly coal_tmo_i cycles after entry to ACCUM unless threshold reached first.
- Threshold: irq_o rises at the edge where the coal_thr_i-th new-event cycle is sampled.
- Simultaneous set and clear of different bits both take effect; same bit → set wins.

## Structure
- Package uart_int_pkg: state enum typedef (IDLE, ACCUM, ASSERT), default parameter constants, source index constants PE=0, FE=1, BRK=2, TX_OV=3, RX_OV=4, RX_DATA=5.
- Sub-module uart_int_src: one source's src_q, edge/level detection and pending bit; instantiated NUM_SRC times via generate. FSM, counters and irq register in top.

## Test plan
- Edge mode, thr=0: pulse src_i[RX_DATA] one cycle → raw_sts_o=6'b100000 and irq_o=1 the next cycle. Clear with clr_i=6'b100000 → irq_o=0 after the clearing edge.
- Level mode, src_i[PE] held high, clear issued → bit stays set, irq_o stays 1. Drop src then clear → irq_o=0.
- Mask: en_i=0, pulse FE → raw_sts_o[1]=1, irq_o=0. Set en_i[1]=1 without a new event → msk_sts_o[1]=1, FSM stays IDLE, irq_o=0. Clear → 0.
- Coalescing thr=3, tmo=0: three new-event cycles on distinct sources spaced 5 cycles apart → evt_cnt_o 1,2,3; irq_o rises after the third. Two events in the same cycle count as 1.
- Timeout thr=10, tmo=20: single event → irq_o rises exactly 20 cycles after ACCUM entry with evt_cnt_o=1.
- Simultaneous set and clear on the same bit → bit remains 1. presetn pulsed low while in ASSERT → all outputs 0 immediately.

Source files
------------

// File: rtl/uart_int_pkg.sv
// Shared types and constants for the UART interrupt controller.
package uart_int_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ASSERT = 2'd2
  } int_state_e;

  localparam int unsigned DEF_NUM_SRC = 6;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_TMO_W   = 16;

  localparam int unsigned PE      = 0;
  localparam int unsigned FE      = 1;
  localparam int unsigned BRK     = 2;
  localparam int unsigned TX_OV   = 3;
  localparam int unsigned RX_OV   = 4;
  localparam int unsigned RX_DATA = 5;

endpackage

// File: rtl/uart_int_src.sv
// One interrupt source: edge/level detection and a sticky pending bit.
module uart_int_src (
  input  logic pclk,
  input  logic presetn,
  input  logic src_i,
  input  logic mode_i,
  input  logic clr_i,
  output logic set_o,
  output logic pend_o,
  output logic nxt_pend_o
);

  logic src_q;

  assign set_o      = mode_i ? (src_i & ~src_q) : src_i;
  // Set takes priority over a clear landing in the same cycle.
  assign nxt_pend_o = set_o | (pend_o & ~clr_i);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      src_q  <= 1'b0;
      pend_o <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_o <= nxt_pend_o;
    end
  end

endmodule

// File: rtl/uart_int_ctrl.sv
// UART interrupt controller: sticky pending bits, masking and event/timeout
// coalescing in front of a single registered interrupt request.
module uart_int_ctrl
  import uart_int_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TMO_W   = DEF_TMO_W
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] mode_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic               clr_we_i,
  input  logic [NUM_SRC-1:0] clr_i,
  input  logic [CNT_W-1:0]   coal_thr_i,
  input  logic [TMO_W-1:0]   coal_tmo_i,
  output logic [NUM_SRC-1:0] raw_sts_o,
  output logic [NUM_SRC-1:0] msk_sts_o,
  output logic [CNT_W-1:0]   evt_cnt_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] nxt_pend;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    uart_int_src u_src (
      .pclk       (pclk),
      .presetn    (presetn),
      .src_i      (src_i[i]),
      .mode_i     (mode_i[i]),
      .clr_i      (clr_we_i & clr_i[i]),
      .set_o      (set_vec[i]),
      .pend_o     (raw_sts_o[i]),
      .nxt_pend_o (nxt_pend[i])
    );
  end

  assign msk_sts_o = raw_sts_o & en_i;

  int_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmr;

  logic             new_evt;
  logic             nxt_msk_any;
  logic [CNT_W-1:0] cnt_upd;
  logic [TMO_W-1:0] tmr_upd;
  logic             thr_hit;
  logic             tmo_hit;
  logic             no_coal;

  always_comb begin
    new_evt     = |(set_vec & en_i & ~raw_sts_o);
    nxt_msk_any = |(nxt_pend & en_i);
    cnt_upd     = cnt;
    if (new_evt && (cnt != '1)) cnt_upd = cnt + 1'b1;
    tmr_upd     = tmr + 1'b1;
    thr_hit     = (cnt_upd >= coal_thr_i);
    tmo_hit     = (coal_tmo_i != '0) && (tmr_upd == coal_tmo_i);
    no_coal     = (coal_thr_i <= CNT_W'(1));
  end

  // irq_o tracks the state being entered so it rises on the same edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      cnt   <= '0;
      tmr   <= '0;
      irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_evt) begin
            if (no_coal) begin
              state <= ASSERT;
              irq_o <= 1'b1;
            end else begin
              state <= ACCUM;
              cnt   <= CNT_W'(1);
              tmr   <= '0;
            end
          end
        end
        ACCUM: begin
          if (!nxt_msk_any) begin
            state <= IDLE;
            cnt   <= '0;
            tmr   <= '0;
            irq_o <= 1'b0;
          end else begin
            cnt <= cnt_upd;
            tmr <= tmr_upd;
            if (thr_hit || tmo_hit) begin
              state <= ASSERT;
              irq_o <= 1'b1;
            end
          end
        end
        ASSERT: begin
          if (!nxt_msk_any) begin
            state <= IDLE;
            cnt   <= '0;
            tmr   <= '0;
            irq_o <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tmr   <= '0;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

  assign evt_cnt_o = cnt;

endmodule
